commit_trace_fifo: RTL
======================

Name: commit_trace_fifo

Overview:
Parametrised commit-trace buffer between the core's retire stage and the simulation/difftest sink. Each retired instruction's record (PC, instruction, GPR write, CSR snapshot) is captured into a DEPTH-entry show-ahead FIFO, stamped with a sequence number, and drained over a valid/ready stream. The block replaces per-cycle unconditional state dumps with a backpressured or lossy stream, selected by MODE.

Parameters:
XLEN, 32, data/PC width
NCSR, 4, number of CSRs in the snapshot (order: mtvec, mepc, mstatus, mcause, then implementation-defined)
DEPTH, 8, FIFO entries; power of two, >=2
SEQW, 32, sequence counter width; wraps
MODE, 0, 0 = stall (backpressure core when full), 1 = drop (never stall; count losses)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous FIFO clear
in_valid  in  1  commit record present
in_ready  out  1  record accepted this cycle
in_pc  in  XLEN  retired PC
in_inst  in  32  retired instruction
in_rd_wen  in  1  GPR written
in_rd_idx  in  5  destination register
in_rd_data  in  XLEN  written value
in_csr_flat  in  NCSR*XLEN  CSR snapshot, CSR0 in LSBs
out_valid  out  1  head record available
out_ready  in  1  sink accepts head
out_pc, out_inst, out_rd_wen, out_rd_idx, out_rd_data, out_csr_flat  out  as inputs  head record payload
out_seq  out  SEQW  head record sequence number
count  out  $clog2(DEPTH+1)  occupancy
overflow  out  1  sticky: at least one record dropped
drop_cnt  out  16  dropped records, saturates at 0xFFFF

Behaviour:
- Reset (reset==0 at posedge): pointers, count, seq counter, overflow, drop_cnt = 0; out_valid=0. Storage array is not reset.
- Payload outputs are gated to 0 while out_valid==0. They show mem[rd_ptr] combinationally otherwise.
- push = in_valid && in_ready && !flush. pop = out_valid && out_ready && !flush.
- in_ready:
  - MODE 0: in_ready = !full && !flush. No pass-through when full, even with a simultaneous pop.
  - MODE 1: in_ready = 1 always.
- MODE 1, record dropped when in_valid && !flush && full && !pop. On a drop: overflow<=1 and drop_cnt increments (saturating). Full with a simultaneous pop: push is stored, no drop.
- Sequence counter: increments by 1 (mod 2^SEQW) on every push and on every drop. A stored record carries the pre-increment value, so gaps in out_seq reveal drops. Wrap from 2^SEQW-1 to 0 is legal.
- Latency: a pushed record appears at out_valid the cycle after the push (registered write; no same-cycle bypass into an empty FIFO).
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- flush:
  - Sets rd_ptr=wr_ptr=0 and count=0 next cycle.
  - Any push or pop in the flush cycle is discarded.
  - seq, overflow and drop_cnt are preserved; in_valid during flush is neither stored nor counted as a drop.
- reset overrides flush and all traffic.
- Reset mid-stream: all queued records are lost; seq restarts at 0.
- count is exact: 0..DEPTH. full = (count==DEPTH), empty = (count==0).

Optional Feature:
Macro COMMIT_TRACE_DPI_EN.
- Defined: the block imports DPI-C void dpi_commit_trace(int pc, int inst, bit rd_wen, int rd_idx, int rd_data, int seq, bit [NCSR*XLEN-1:0] csrs). It calls this at each posedge with reset==1 && pop, passing the head record.
- Also defined: on the cycle overflow first rises, it calls dpi_trace_overflow(int seq).
- Not defined: no DPI import; the block is fully synthesizable and the stream ports are the only outputs.

Test Plan:
- Reset/basic (DEPTH=4, MODE 0): hold reset=0 3 cycles -> out_valid=0, count=0, payload=0. Push pc=0x80000000, rd_idx=5, rd_data=0x1234, out_ready=1 -> next cycle out_valid=1, out_pc=0x80000000, out_seq=0; following cycle count=0.
- Stall (MODE 0): out_ready=0, push 5 records -> first 4 accepted, count=4, in_ready=0 on the 5th. Raise out_ready 1 cycle -> count=3, in_ready=1; 5th record lands with seq=4.
- Drop (MODE 1, DEPTH=4): out_ready=0, push 6 records -> count=4, overflow=1, drop_cnt=2. Drain -> out_seq 0,1,2,3. Next push gets seq=6.
- Full push+pop (MODE 1): FIFO full, in_valid=1 and out_ready=1 same cycle -> no drop, count stays 4, pointers wrap correctly over 3 laps, FIFO order preserved.
- Flush: 3 records queued, overflow=1; assert flush with in_valid=1 -> next cycle count=0, out_valid=0, overflow=1, seq unchanged. The record presented during flush is absent from the output.
- Seq wrap (SEQW=4): push 18 records with out_ready=1 -> out_seq runs 0..15,0,1.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// Commit-trace buffer: a show-ahead FIFO of retired-instruction records with sequence stamping,
// backpressure (MODE 0) or lossy drop (MODE 1).
module commit_trace_fifo #(
    parameter int XLEN  = 32,
    parameter int NCSR  = 4,
    parameter int DEPTH = 8,
    parameter int SEQW  = 32,
    parameter int MODE  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_inst,
    input  logic                     in_rd_wen,
    input  logic [4:0]               in_rd_idx,
    input  logic [XLEN-1:0]          in_rd_data,
    input  logic [NCSR*XLEN-1:0]     in_csr_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_rd_wen,
    output logic [4:0]               out_rd_idx,
    output logic [XLEN-1:0]          out_rd_data,
    output logic [NCSR*XLEN-1:0]     out_csr_flat,
    output logic [SEQW-1:0]          out_seq,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [31:0]          inst;
        logic                 rd_wen;
        logic [4:0]           rd_idx;
        logic [XLEN-1:0]      rd_data;
        logic [NCSR*XLEN-1:0] csr;
        logic [SEQW-1:0]      seq;
    } rec_t;

    rec_t            mem_r [DEPTH];
    rec_t            head_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [SEQW-1:0] seq_r;
    logic            overflow_r;
    logic [15:0]     drop_cnt_r;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    logic            in_ready_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign head_s  = mem_r[rd_ptr_r];

    // Handshake decode; a full FIFO in drop mode still stores when the head leaves this cycle.
    always_comb begin
        pop_s = !empty_s && out_ready && !flush;
        if (MODE == 0) begin
            in_ready_s = !full_s && !flush;
            push_s     = in_valid && in_ready_s;
            drop_s     = 1'b0;
        end else begin
            in_ready_s = 1'b1;
            push_s     = in_valid && !flush && (!full_s || pop_s);
            drop_s     = in_valid && !flush && full_s && !pop_s;
        end
    end

    // Pointer, occupancy, sequence and loss-accounting state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            seq_r      <= {SEQW{1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
            // Drops consume a sequence number so the sink sees the gap.
            if (push_s || drop_s) begin
                seq_r <= seq_r + SEQW'(1'b1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_r <= drop_cnt_r + 16'h0001;
                end
            end
        end
    end

    // Record storage; intentionally not reset, the gated payload hides stale entries.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= '{pc: in_pc, inst: in_inst, rd_wen: in_rd_wen, rd_idx: in_rd_idx,
                                 rd_data: in_rd_data, csr: in_csr_flat, seq: seq_r};
        end
    end

    // Head payload, forced to zero while nothing is queued.
    always_comb begin
        if (empty_s) begin
            out_pc       = {XLEN{1'b0}};
            out_inst     = 32'h0000_0000;
            out_rd_wen   = 1'b0;
            out_rd_idx   = 5'd0;
            out_rd_data  = {XLEN{1'b0}};
            out_csr_flat = {(NCSR*XLEN){1'b0}};
            out_seq      = {SEQW{1'b0}};
        end else begin
            out_pc       = head_s.pc;
            out_inst     = head_s.inst;
            out_rd_wen   = head_s.rd_wen;
            out_rd_idx   = head_s.rd_idx;
            out_rd_data  = head_s.rd_data;
            out_csr_flat = head_s.csr;
            out_seq      = head_s.seq;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = !empty_s;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule
